imem_fetch_responder: RTL

- Instruction-memory responder at the far end of the fetch path: accepts a fetch address from the PC/fetch stage, returns one 32-bit instruction word after a fixed wait-state latency.
- Word-addressed program store mapped at the MIPS text base 0x00400000.
- Valid/ready handshake on both the request and response sides.
- Side load port for program preload by bench or boot logic.

---
 rtl/imem_fetch_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one fetch at a time, fixed wait-state latency, word store at BASE_ADDR.
// Optional fetch handshake counter enabled by defining IMEM_PERF_EN (adds output fetch_count).
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h00400000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_data,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_index,
  input  logic [31:0]                    ld_data
`ifdef IMEM_PERF_EN
  ,
  output logic [31:0]                    fetch_count
`endif
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] addr_p0;
  logic [31:0] addr_off;
  logic [31:0] word_off;
  logic        fetch_err;
  logic [IW-1:0] word_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // Unsigned subtraction makes addresses below the base wrap to huge offsets,
  // so a single bound check covers both sides of the window.
  always_comb begin
    addr_off  = addr_p0 - BASE_ADDR;
    word_off  = addr_off >> 2;
    fetch_err = (addr_p0[1:0] != 2'b00) || (word_off >= DEPTH_WORDS);
    word_idx  = word_off[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)    state_nx = WAIT;
      WAIT:    if (cnt == 4'd0)  state_nx = RESP;
      RESP:    if (rsp_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Stage p0: request address captured on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) addr_p0 <= req_addr;
  end

  // Wait-state counter and the registered response word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) cnt <= LAT4;
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err  <= fetch_err;
            rsp_data <= fetch_err ? 32'd0 : mem[word_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // A load landing on the read edge is seen only by later fetches.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_index] <= ld_data;
  end

`ifdef IMEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         fetch_count <= 32'd0;
    else if (rsp_valid && rsp_ready) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
